// File: rtl/reduction_offload_arbiter.sv
// -----------------------------------------------------------------------------
// reduction_offload_arbiter
//
// Shares one in-order reduction backend between NumChannels offload clients.
// Requests are granted round-robin and forwarded to the backend with zero
// latency. The granted channel index is pushed into a small circular index
// FIFO. Because the backend answers strictly in order, the FIFO head always
// names the channel that owns the next response.
//
// Ports
//   clk_i / rst_ni        clock, asynchronous active-low reset
//   ch_req_*              per-channel request (op, operands, valid/ready),
//                         flattened with channel 0 in the LSBs
//   ch_resp_*             per-channel response. The result is replicated to
//                         every channel and valid is one-hot.
//   be_req_*              request towards the shared backend
//   be_resp_*             response from the shared backend
//   outstanding_o         requests currently in flight at the backend
//   err_o                 sticky flag: a response arrived with nothing in flight
// -----------------------------------------------------------------------------
module reduction_offload_arbiter #(
  parameter int unsigned NumChannels    = 2,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned OpWidth        = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumChannels*OpWidth-1:0]   ch_req_op_i,
  input  logic [NumChannels*DataWidth-1:0] ch_req_operand1_i,
  input  logic [NumChannels*DataWidth-1:0] ch_req_operand2_i,
  input  logic [NumChannels-1:0]           ch_req_valid_i,
  output logic [NumChannels-1:0]           ch_req_ready_o,
  output logic [NumChannels*DataWidth-1:0] ch_resp_result_o,
  output logic [NumChannels-1:0]           ch_resp_valid_o,
  input  logic [NumChannels-1:0]           ch_resp_ready_i,
  output logic [OpWidth-1:0]               be_req_op_o,
  output logic [DataWidth-1:0]             be_req_operand1_o,
  output logic [DataWidth-1:0]             be_req_operand2_o,
  output logic                             be_req_valid_o,
  input  logic                             be_req_ready_i,
  input  logic [DataWidth-1:0]             be_resp_result_i,
  input  logic                             be_resp_valid_i,
  output logic                             be_resp_ready_o,
  output logic [CntWidth-1:0]              outstanding_o,
  output logic                             err_o
);

  localparam int unsigned IdxWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef logic [IdxWidth-1:0] idx_t;
  typedef logic [PtrWidth-1:0] ptr_t;

  // Channel reached by stepping 'off' places past 'base', wrapping at NumChannels.
  function automatic idx_t rr_index(idx_t base, int unsigned off);
    return idx_t'((32'(base) + off) % NumChannels);
  endfunction

  function automatic ptr_t ptr_inc(ptr_t p);
    return (32'(p) == MaxOutstanding - 1) ? '0 : p + ptr_t'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  idx_t                rr_ptr_q,   rr_ptr_d;
  logic                lock_q,     lock_d;
  idx_t                lock_idx_q, lock_idx_d;
  logic                err_q,      err_d;
  ptr_t                wr_ptr_q,   wr_ptr_d;
  ptr_t                rd_ptr_q,   rd_ptr_d;
  logic [CntWidth-1:0] count_q,    count_d;
  idx_t                idx_mem_q [MaxOutstanding];

  logic full, empty;
  logic grant_found;
  idx_t grant_idx;
  logic req_vld;
  idx_t head_idx;
  logic push, pop;

  assign full     = (count_q == CntWidth'(MaxOutstanding));
  assign empty    = (count_q == '0);
  assign head_idx = idx_mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Arbitration. A locked grant overrides the round-robin search, so a channel
  // that raises valid later cannot displace a request the backend has not yet
  // accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so that no path
    // through the block leaves it unassigned and infers a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    if (lock_q) begin
      grant_found = 1'b1;
      grant_idx   = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < NumChannels; i++) begin
        if (!grant_found && ch_req_valid_i[rr_index(rr_ptr_q, i)]) begin
          grant_found = 1'b1;
          grant_idx   = rr_index(rr_ptr_q, i);
        end
      end
    end
  end

  assign req_vld = grant_found & ch_req_valid_i[grant_idx];

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  always_comb begin
    be_req_op_o       = ch_req_op_i[32'(grant_idx)*OpWidth +: OpWidth];
    be_req_operand1_o = ch_req_operand1_i[32'(grant_idx)*DataWidth +: DataWidth];
    be_req_operand2_o = ch_req_operand2_i[32'(grant_idx)*DataWidth +: DataWidth];
    be_req_valid_o    = req_vld & ~full;
    ch_req_ready_o    = '0;
    if (req_vld && !full) begin
      ch_req_ready_o[grant_idx] = be_req_ready_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Response path. With the FIFO empty, a response is still accepted (and
  // dropped) so the backend cannot deadlock. That event raises err_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    ch_resp_result_o = {NumChannels{be_resp_result_i}};
    ch_resp_valid_o  = '0;
    if (empty) begin
      be_resp_ready_o = be_resp_valid_i;
    end else begin
      be_resp_ready_o           = ch_resp_ready_i[head_idx];
      ch_resp_valid_o[head_idx] = be_resp_valid_i;
    end
  end

  // The push is gated by !full and never by the pop. Request ready therefore
  // never depends on the response handshake.
  assign push = be_req_valid_o & be_req_ready_i;
  assign pop  = be_resp_valid_i & be_resp_ready_o & ~empty;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = be_req_valid_o & ~be_req_ready_i;
    lock_idx_d = grant_idx;
    err_d      = err_q | (be_resp_valid_i & empty);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      rr_ptr_d = (32'(grant_idx) == NumChannels - 1) ? '0 : grant_idx + idx_t'(1);
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the index storage is deliberately not reset. An entry is only read
  // after a push has written it, and reset empties the FIFO through the count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      idx_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_reduction_offload_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reduction_offload_arbiter
//
// Directed bench for reduction_offload_arbiter with the default parameters
// (2 channels, 64-bit data, 4-bit op, depth 4). The bench plays the role of
// both clients and the backend. Expected values are written by hand per
// vector.
// -----------------------------------------------------------------------------
module tb_reduction_offload_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned OW = 4;
  localparam int unsigned MO = 4;
  localparam int unsigned CW = $clog2(MO + 1);

  logic              clk;
  logic              rst_n;
  logic [N*OW-1:0]   ch_req_op;
  logic [N*DW-1:0]   ch_req_operand1;
  logic [N*DW-1:0]   ch_req_operand2;
  logic [N-1:0]      ch_req_valid;
  logic [N-1:0]      ch_req_ready;
  logic [N*DW-1:0]   ch_resp_result;
  logic [N-1:0]      ch_resp_valid;
  logic [N-1:0]      ch_resp_ready;
  logic [OW-1:0]     be_req_op;
  logic [DW-1:0]     be_req_operand1;
  logic [DW-1:0]     be_req_operand2;
  logic              be_req_valid;
  logic              be_req_ready;
  logic [DW-1:0]     be_resp_result;
  logic              be_resp_valid;
  logic              be_resp_ready;
  logic [CW-1:0]     outstanding;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  reduction_offload_arbiter #(
    .NumChannels   (N),
    .DataWidth     (DW),
    .OpWidth       (OW),
    .MaxOutstanding(MO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .ch_req_op_i      (ch_req_op),
    .ch_req_operand1_i(ch_req_operand1),
    .ch_req_operand2_i(ch_req_operand2),
    .ch_req_valid_i   (ch_req_valid),
    .ch_req_ready_o   (ch_req_ready),
    .ch_resp_result_o (ch_resp_result),
    .ch_resp_valid_o  (ch_resp_valid),
    .ch_resp_ready_i  (ch_resp_ready),
    .be_req_op_o      (be_req_op),
    .be_req_operand1_o(be_req_operand1),
    .be_req_operand2_o(be_req_operand2),
    .be_req_valid_o   (be_req_valid),
    .be_req_ready_i   (be_req_ready),
    .be_resp_result_i (be_resp_result),
    .be_resp_valid_i  (be_resp_valid),
    .be_resp_ready_o  (be_resp_ready),
    .outstanding_o    (outstanding),
    .err_o            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ch_req_op       = '0;
    ch_req_operand1 = '0;
    ch_req_operand2 = '0;
    ch_req_valid    = '0;
    ch_resp_ready   = '0;
    be_req_ready    = 1'b0;
    be_resp_result  = '0;
    be_resp_valid   = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic [OW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    ch_req_op[ch*OW +: OW]       = op;
    ch_req_operand1[ch*DW +: DW] = a;
    ch_req_operand2[ch*DW +: DW] = b;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [N-1:0] oh;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    // ---------------- reset state ----------------
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_be_req_valid", 64'(be_req_valid), 64'd0);
    check("rst_ch_req_ready", 64'(ch_req_ready), 64'd0);
    check("rst_ch_resp_valid", 64'(ch_resp_valid), 64'd0);
    check("rst_be_resp_ready", 64'(be_resp_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // ---------------- single channel: 3 op 4 -> 7 ----------------
    set_req(0, 4'd1, 64'd3, 64'd4);
    ch_req_valid = 2'b01;
    be_req_ready = 1'b1;
    #1;
    check("single_be_valid", 64'(be_req_valid), 64'd1);
    check("single_op", 64'(be_req_op), 64'd1);
    check("single_opnd1", be_req_operand1, 64'd3);
    check("single_opnd2", be_req_operand2, 64'd4);
    check("single_ch_ready", 64'(ch_req_ready), 64'b01);
    tick();
    ch_req_valid   = 2'b00;
    be_resp_valid  = 1'b1;
    be_resp_result = 64'd7;
    ch_resp_ready  = 2'b11;
    #1;
    check("single_outst1", 64'(outstanding), 64'd1);
    check("single_resp_valid", 64'(ch_resp_valid), 64'b01);
    check("single_result_ch0", ch_resp_result[0 +: DW], 64'd7);
    check("single_result_ch1", ch_resp_result[DW +: DW], 64'd7);
    check("single_be_resp_ready", 64'(be_resp_ready), 64'd1);
    tick();
    be_resp_valid = 1'b0;
    #1;
    check("single_outst0", 64'(outstanding), 64'd0);

    // ---------------- contention: grants 0,1,0,1 then full ----------------
    apply_reset();
    set_req(0, 4'd2, 64'h10, 64'h20);
    set_req(1, 4'd3, 64'h30, 64'h40);
    ch_req_valid = 2'b11;
    be_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_op", 64'(be_req_op), (i % 2 == 0) ? 64'd2 : 64'd3);
      check("cont_ready", 64'(ch_req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
      check("cont_outst", 64'(outstanding), 64'(i));
      tick();
    end
    #1;
    check("full_outst", 64'(outstanding), 64'd4);
    check("full_ch_ready", 64'(ch_req_ready), 64'd0);
    check("full_be_valid", 64'(be_req_valid), 64'd0);
    ch_req_valid  = 2'b00;
    ch_resp_ready = 2'b11;
    be_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      be_resp_result = 64'hA + 64'(i);
      #1;
      check("cont_resp_valid", 64'(ch_resp_valid), (i % 2 == 0) ? 64'b01 : 64'b10);
      check("cont_resp_data", ch_resp_result[((i % 2) * DW) +: DW], 64'hA + 64'(i));
      tick();
    end
    be_resp_valid = 1'b0;
    #1;
    check("cont_drained", 64'(outstanding), 64'd0);

    // ---------------- grant lock: ch1 held, ch0 raises valid ----------------
    ch_req_valid = 2'b10;
    be_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lock_op", 64'(be_req_op), 64'd3);
      check("lock_opnd1", be_req_operand1, 64'h30);
      check("lock_be_valid", 64'(be_req_valid), 64'd1);
      check("lock_ch_ready", 64'(ch_req_ready), 64'd0);
      tick();
      ch_req_valid = 2'b11;
    end
    be_req_ready = 1'b1;
    #1;
    check("lock_release_op", 64'(be_req_op), 64'd3);
    check("lock_release_ready", 64'(ch_req_ready), 64'b10);
    tick();
    ch_req_valid = 2'b01;
    #1;
    check("lock_next_op", 64'(be_req_op), 64'd2);
    check("lock_next_ready", 64'(ch_req_ready), 64'b01);
    tick();
    ch_req_valid = 2'b00;
    #1;
    check("lock_outst", 64'(outstanding), 64'd2);

    // ---------------- backpressure: head ch1 stalls ----------------
    be_resp_valid  = 1'b1;
    be_resp_result = 64'h11;
    ch_resp_ready  = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_be_resp_ready", 64'(be_resp_ready), 64'd0);
      check("bp_resp_valid", 64'(ch_resp_valid), 64'b10);
      check("bp_outst", 64'(outstanding), 64'd2);
      tick();
    end
    ch_resp_ready = 2'b11;
    #1;
    check("bp_release_ready", 64'(be_resp_ready), 64'd1);
    check("bp_release_data", ch_resp_result[DW +: DW], 64'h11);
    tick();
    be_resp_result = 64'h22;
    #1;
    check("bp_second_valid", 64'(ch_resp_valid), 64'b01);
    check("bp_second_data", ch_resp_result[0 +: DW], 64'h22);
    tick();
    be_resp_valid = 1'b0;
    #1;
    check("bp_drained", 64'(outstanding), 64'd0);

    // ---------------- full with simultaneous pop ----------------
    set_req(0, 4'd5, 64'h50, 64'h60);
    ch_req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fill_ready", 64'(ch_req_ready), 64'b01);
      tick();
    end
    be_resp_valid  = 1'b1;
    be_resp_result = 64'h77;
    #1;
    check("fullpop_outst", 64'(outstanding), 64'd4);
    check("fullpop_ch_ready", 64'(ch_req_ready), 64'd0);
    check("fullpop_resp_valid", 64'(ch_resp_valid), 64'b01);
    tick();
    be_resp_valid = 1'b0;
    #1;
    check("after_pop_outst", 64'(outstanding), 64'd3);
    check("after_pop_ready", 64'(ch_req_ready), 64'b01);
    tick();
    ch_req_valid = 2'b00;
    #1;
    check("refill_outst", 64'(outstanding), 64'd4);
    be_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_resp_valid", 64'(ch_resp_valid), 64'b01);
      tick();
    end
    be_resp_valid = 1'b0;
    #1;
    check("drain_outst", 64'(outstanding), 64'd0);

    // ---------------- wrap: 10 transactions, push and pop together ----------------
    set_req(1, 4'd6, 64'h70, 64'h80);
    for (int i = 0; i < 10; i++) begin
      ch_req_valid  = (i % 2 == 0) ? 2'b01 : 2'b10;
      be_resp_valid = (i > 0);
      #1;
      check("wrap_req_ready", 64'(ch_req_ready), 64'(ch_req_valid));
      check("wrap_outst", 64'(outstanding), (i > 0) ? 64'd1 : 64'd0);
      oh = (i > 0) ? (((i - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check("wrap_resp_valid", 64'(ch_resp_valid), 64'(oh));
      tick();
    end
    ch_req_valid  = 2'b00;
    be_resp_valid = 1'b1;
    #1;
    check("wrap_last_resp", 64'(ch_resp_valid), 64'b10);
    tick();
    be_resp_valid = 1'b0;
    #1;
    check("wrap_outst_end", 64'(outstanding), 64'd0);

    // ---------------- spurious response ----------------
    check("pre_spur_err", 64'(err), 64'd0);
    be_resp_valid = 1'b1;
    #1;
    check("spur_be_resp_ready", 64'(be_resp_ready), 64'd1);
    check("spur_resp_valid", 64'(ch_resp_valid), 64'd0);
    tick();
    be_resp_valid = 1'b0;
    #1;
    check("spur_err_set", 64'(err), 64'd1);
    tick();
    tick();
    check("spur_err_sticky", 64'(err), 64'd1);
    check("spur_outst", 64'(outstanding), 64'd0);

    // ---------------- asynchronous reset mid-transfer ----------------
    ch_req_valid = 2'b01;
    #1;
    tick();
    ch_req_valid = 2'b00;
    #1;
    check("mid_outst_before", 64'(outstanding), 64'd1);
    #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("mid_rst_outst", 64'(outstanding), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_be_valid", 64'(be_req_valid), 64'd0);
    check("mid_rst_ch_ready", 64'(ch_req_ready), 64'd0);
    check("mid_rst_resp_valid", 64'(ch_resp_valid), 64'd0);
    check("mid_rst_be_resp_ready", 64'(be_resp_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
